// File: rtl/ifm_pingpong_receiver_if.sv
// rtl/ifm_pingpong_receiver_if.sv - producer/consumer signal bundle for the ping-pong IFM receiver
interface ifm_pingpong_receiver_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_SIZE_IFM = 10,
  parameter int PLANE_BITS       = 3
);
  // producer (previous layer) side
  logic [DATA_WIDTH-1:0]       data_in_from_previous;
  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write_previous;
  logic                        ifm_enable_write_previous;
  logic                        start_from_previous;
  logic                        end_to_previous;
  // consumer (next layer) side
  logic                        ifm_enable_read_next;
  logic [PLANE_BITS-1:0]       ifm_plane_read_next;
  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_next;
  logic [DATA_WIDTH-1:0]       data_out_for_next;
  logic                        data_valid_next;
  logic                        start_to_next;
  logic                        end_from_next;
  // status
  logic                        overflow_error;

  modport master (
    output data_in_from_previous, ifm_address_write_previous, ifm_enable_write_previous,
    output start_from_previous, ifm_enable_read_next, ifm_plane_read_next,
    output ifm_address_read_next, end_from_next,
    input  end_to_previous, data_out_for_next, data_valid_next, start_to_next, overflow_error
  );

  modport slave (
    input  data_in_from_previous, ifm_address_write_previous, ifm_enable_write_previous,
    input  start_from_previous, ifm_enable_read_next, ifm_plane_read_next,
    input  ifm_address_read_next, end_from_next,
    output end_to_previous, data_out_for_next, data_valid_next, start_to_next, overflow_error
  );
endinterface

// File: rtl/ifm_pingpong_receiver.sv
// rtl/ifm_pingpong_receiver.sv - two-bank ping-pong buffer between a producing and a consuming conv layer
module ifm_pingpong_receiver #(
  parameter int  DATA_WIDTH       = 32,
  parameter int  IFM_SIZE         = 28,
  parameter int  NUMBER_OF_IFM    = 6,
  localparam int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  localparam int PLANE_BITS       = (NUMBER_OF_IFM > 1) ? $clog2(NUMBER_OF_IFM) : 1
) (
  input logic                   clk,
  input logic                   reset,
  ifm_pingpong_receiver_if.slave bus
);

  localparam int PLANE_WORDS = IFM_SIZE * IFM_SIZE;
  localparam int BANK_WORDS  = NUMBER_OF_IFM * PLANE_WORDS;
  localparam int DEPTH       = 2 * BANK_WORDS;
  localparam int IDX_W       = $clog2(DEPTH);

  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_ADDR  = ADDRESS_SIZE_IFM'(PLANE_WORDS - 1);
  localparam logic [PLANE_BITS-1:0]       LAST_PLANE = PLANE_BITS'(NUMBER_OF_IFM - 1);

  typedef enum logic [1:0] {
    B_FREE    = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2,
    B_READING = 2'd3
  } bank_state_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_ACTIVE = 1'b1
  } rd_state_t;

  bank_state_t                bank_q [2];
  bank_state_t                bank_d [2];
  rd_state_t                  rd_state_q, rd_state_d;
  logic                       wr_bank_q, wr_bank_d;
  logic                       rd_bank_q, rd_bank_d;
  logic [PLANE_BITS-1:0]      wr_plane_q, wr_plane_d;
  logic                       ovf_q, ovf_d;
  logic                       end_prev_q, end_prev_d;
  logic                       wr_open;
  logic                       handover;
  logic                       mem_we;
  logic [IDX_W-1:0]           wr_idx;
  logic [IDX_W-1:0]           rd_idx;
  logic                       rd_in_range;
  logic [DATA_WIDTH-1:0]      rd_data_q;
  logic                       rd_valid_q;

  logic [DATA_WIDTH-1:0]      mem [DEPTH];

  // Flat word index; arithmetic rather than concatenation so the array is exactly two banks deep
  function automatic logic [IDX_W-1:0] word_index(input logic bank,
                                                  input logic [PLANE_BITS-1:0] plane,
                                                  input logic [ADDRESS_SIZE_IFM-1:0] addr);
    int idx;
    idx = int'(bank) * BANK_WORDS + int'(plane) * PLANE_WORDS + int'(addr);
    return IDX_W'(idx);
  endfunction

  // Out-of-range plane/address would spill into the neighbouring bank; such accesses are suppressed
  function automatic logic in_range(input logic [PLANE_BITS-1:0] plane,
                                    input logic [ADDRESS_SIZE_IFM-1:0] addr);
    return (int'(plane) < NUMBER_OF_IFM) && (int'(addr) < PLANE_WORDS);
  endfunction

  assign wr_idx      = word_index(wr_bank_q, wr_plane_q, bus.ifm_address_write_previous);
  assign rd_idx      = word_index(rd_bank_q, bus.ifm_plane_read_next, bus.ifm_address_read_next);
  assign rd_in_range = in_range(bus.ifm_plane_read_next, bus.ifm_address_read_next);

  // Handover is a Moore decision from registered state, so start_to_next is a clean 1-cycle pulse
  assign handover = (rd_state_q == RD_IDLE) && (bank_q[rd_bank_q] == B_FULL);
  assign wr_open  = (bank_q[wr_bank_q] == B_FREE) || (bank_q[wr_bank_q] == B_FILLING);

  // Next-state logic for both bank FSMs, the producer pointers and the consumer FSM
  always_comb begin
    bank_d     = bank_q;
    rd_state_d = rd_state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_plane_d = wr_plane_q;
    ovf_d      = ovf_q;
    mem_we     = 1'b0;

    // Producer write: lands in the current write bank, even if that bank closes this same cycle
    if (bus.ifm_enable_write_previous) begin
      if (wr_open) begin
        mem_we            = in_range(wr_plane_q, bus.ifm_address_write_previous);
        bank_d[wr_bank_q] = B_FILLING;
        if (bus.ifm_address_write_previous == LAST_ADDR && wr_plane_q != LAST_PLANE) begin
          wr_plane_d = wr_plane_q + 1'b1;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Producer close: overrides the FILLING set above and swaps to the other bank
    if (bus.start_from_previous) begin
      if (wr_open) begin
        bank_d[wr_bank_q] = B_FULL;
        wr_bank_d         = ~wr_bank_q;
        wr_plane_d        = '0;
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Consumer side only touches FULL/READING banks, the producer only FREE/FILLING ones
    unique case (rd_state_q)
      RD_IDLE: begin
        if (handover) begin
          bank_d[rd_bank_q] = B_READING;
          rd_state_d        = RD_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        if (bus.end_from_next) begin
          bank_d[rd_bank_q] = B_FREE;
          rd_bank_d         = ~rd_bank_q;
          rd_state_d        = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    end_prev_d = (bank_d[wr_bank_d] == B_FREE) || (bank_d[wr_bank_d] == B_FILLING);
  end

  // Handshake state register; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_q[0]  <= B_FREE;
      bank_q[1]  <= B_FREE;
      rd_state_q <= RD_IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_plane_q <= '0;
      ovf_q      <= 1'b0;
      end_prev_q <= 1'b1;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      rd_state_q <= rd_state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_plane_q <= wr_plane_d;
      ovf_q      <= ovf_d;
      end_prev_q <= end_prev_d;
    end
  end

  // Storage write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= bus.data_in_from_previous;
    end
  end

  // Registered read port: one-cycle latency, data holds between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.ifm_enable_read_next;
      if (bus.ifm_enable_read_next) begin
        rd_data_q <= rd_in_range ? mem[rd_idx] : '0;
      end
    end
  end

  assign bus.end_to_previous   = end_prev_q;
  assign bus.start_to_next     = handover;
  assign bus.data_out_for_next = rd_data_q;
  assign bus.data_valid_next   = rd_valid_q;
  assign bus.overflow_error    = ovf_q;

endmodule

// File: tb/tb_ifm_pingpong_receiver.sv
// tb/tb_ifm_pingpong_receiver.sv - randomized, model-checked bench for ifm_pingpong_receiver
module tb_ifm_pingpong_receiver;

  localparam int DW  = 32;
  localparam int SZ  = 4;
  localparam int NP  = 2;
  localparam int PW  = SZ * SZ;
  localparam int AW  = 4;
  localparam int PB  = 1;

  localparam int S_FREE    = 0;
  localparam int S_FILLING = 1;
  localparam int S_FULL    = 2;
  localparam int S_READING = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  ifm_pingpong_receiver_if #(.DATA_WIDTH(DW), .ADDRESS_SIZE_IFM(AW), .PLANE_BITS(PB)) bus ();

  ifm_pingpong_receiver #(.DATA_WIDTH(DW), .IFM_SIZE(SZ), .NUMBER_OF_IFM(NP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0] m_mem     [2][NP][PW];
  bit            m_written [2][NP][PW];
  int            m_bank [2];
  int            m_wr_bank, m_rd_bank, m_wr_plane;
  bit            m_active, m_ovf, m_valid, m_known;
  logic [DW-1:0] m_data;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_open(input int b);
    return (m_bank[b] == S_FREE) || (m_bank[b] == S_FILLING);
  endfunction

  task automatic model_reset();
    m_bank[0] = S_FREE; m_bank[1] = S_FREE;
    m_wr_bank = 0; m_rd_bank = 0; m_wr_plane = 0;
    m_active = 0; m_ovf = 0; m_valid = 0; m_data = '0; m_known = 1;
  endtask

  task automatic model_edge();
    bit  rd_full_before;
    int  a, p;
    rd_full_before = (m_bank[m_rd_bank] == S_FULL);
    if (bus.ifm_enable_read_next) begin
      p = int'(bus.ifm_plane_read_next);
      a = int'(bus.ifm_address_read_next);
      m_valid = 1;
      m_data  = m_mem[m_rd_bank][p][a];
      m_known = m_active && m_written[m_rd_bank][p][a];
    end else begin
      m_valid = 0;
    end
    if (bus.ifm_enable_write_previous) begin
      if (m_open(m_wr_bank)) begin
        a = int'(bus.ifm_address_write_previous);
        m_mem[m_wr_bank][m_wr_plane][a]     = bus.data_in_from_previous;
        m_written[m_wr_bank][m_wr_plane][a] = 1;
        m_bank[m_wr_bank] = S_FILLING;
        if (a == PW - 1 && m_wr_plane < NP - 1) m_wr_plane++;
      end else begin
        m_ovf = 1;
      end
    end
    if (bus.start_from_previous) begin
      if (m_open(m_wr_bank)) begin
        m_bank[m_wr_bank] = S_FULL;
        m_wr_bank  = 1 - m_wr_bank;
        m_wr_plane = 0;
      end else begin
        m_ovf = 1;
      end
    end
    if (!m_active) begin
      if (rd_full_before) begin
        m_bank[m_rd_bank] = S_READING;
        m_active = 1;
      end
    end else if (bus.end_from_next) begin
      m_bank[m_rd_bank] = S_FREE;
      m_rd_bank = 1 - m_rd_bank;
      m_active  = 0;
    end
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ".end_to_previous"}, bus.end_to_previous, m_open(m_wr_bank));
    check_eq({where, ".start_to_next"}, bus.start_to_next,
             (!m_active && m_bank[m_rd_bank] == S_FULL));
    check_eq({where, ".data_valid_next"}, bus.data_valid_next, m_valid);
    check_eq({where, ".overflow_error"}, bus.overflow_error, m_ovf);
    if (m_known) check_eq({where, ".data_out"}, bus.data_out_for_next, m_data);
  endtask

  task automatic idle_inputs();
    bus.data_in_from_previous      = '0;
    bus.ifm_address_write_previous = '0;
    bus.ifm_enable_write_previous  = 1'b0;
    bus.start_from_previous        = 1'b0;
    bus.ifm_enable_read_next       = 1'b0;
    bus.ifm_plane_read_next        = '0;
    bus.ifm_address_read_next      = '0;
    bus.end_from_next              = 1'b0;
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(where);
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    reset = 1'b1;
  endtask

  task automatic write_word(input int addr, input logic [DW-1:0] data, input string where);
    bus.ifm_enable_write_previous  = 1'b1;
    bus.ifm_address_write_previous = AW'(addr);
    bus.data_in_from_previous      = data;
    step(where);
  endtask

  task automatic read_word(input int plane, input int addr, input logic [DW-1:0] exp,
                           input string where);
    bus.ifm_enable_read_next  = 1'b1;
    bus.ifm_plane_read_next   = PB'(plane);
    bus.ifm_address_read_next = AW'(addr);
    step(where);
    check_eq({where, ".data"}, bus.data_out_for_next, exp);
    check_eq({where, ".valid"}, bus.data_valid_next, 1);
  endtask

  task automatic close_bank(input string where);
    bus.start_from_previous = 1'b1;
    step(where);
  endtask

  initial begin
    idle_inputs();
    do_reset();
    check_eq("reset.end_to_previous", bus.end_to_previous, 1);
    check_eq("reset.data_out", bus.data_out_for_next, 0);

    // T1: fill bank0 with data = index, close it
    for (int i = 0; i < NP * PW; i++) write_word(i % PW, DW'(i), "t1.fill");
    close_bank("t1.close");
    check_eq("t1.start_pulse", bus.start_to_next, 1);
    check_eq("t1.end_prev", bus.end_to_previous, 1);
    step("t1.after");
    check_eq("t1.start_done", bus.start_to_next, 0);

    // T2: plane1 addr5 of bank0 holds 16+5
    read_word(1, 5, 21, "t2.read");
    step("t2.hold");
    check_eq("t2.valid_drop", bus.data_valid_next, 0);
    check_eq("t2.data_hold", bus.data_out_for_next, 21);

    // T3: fill and close bank1 while bank0 still being read
    for (int i = 0; i < NP * PW; i++) write_word(i % PW, DW'(100 + i), "t3.fill");
    close_bank("t3.close");
    check_eq("t3.end_prev", bus.end_to_previous, 0);
    write_word(3, 32'hdead, "t3.extra");
    check_eq("t3.overflow", bus.overflow_error, 1);
    read_word(0, 7, 7, "t3.read_bank0");

    // T4: end_from_next and a (rejected) close in the same cycle
    bus.end_from_next       = 1'b1;
    bus.start_from_previous = 1'b1;
    step("t4.both");
    check_eq("t4.start_pulse", bus.start_to_next, 1);
    check_eq("t4.end_prev", bus.end_to_previous, 1);
    step("t4.after");
    read_word(0, 2, 102, "t4.read_bank1");

    // T5: asynchronous reset in the middle of a fill
    bus.end_from_next = 1'b1;
    step("t5.free");
    for (int i = 0; i < 10; i++) write_word(i, DW'(500 + i), "t5.partial");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("t5.async.end_prev", bus.end_to_previous, 1);
    check_eq("t5.async.start", bus.start_to_next, 0);
    check_eq("t5.async.valid", bus.data_valid_next, 0);
    check_eq("t5.async.data", bus.data_out_for_next, 0);
    check_eq("t5.async.ovf", bus.overflow_error, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < PW; i++) write_word(i, DW'(600 + i), "t5.refill");
    close_bank("t5.close");
    check_eq("t5.start_pulse", bus.start_to_next, 1);
    step("t5.after");
    read_word(0, 3, 603, "t5.read");

    // T6: repeated writes to the last address saturate the plane counter
    do_reset();
    for (int k = 0; k < 4; k++) write_word(PW - 1, DW'(700 + k), "t6.last");
    write_word(0, 800, "t6.first");
    close_bank("t6.close");
    check_eq("t6.end_prev", bus.end_to_previous, 1);
    step("t6.after");
    read_word(0, PW - 1, 700, "t6.plane0");
    read_word(1, PW - 1, 703, "t6.plane1");
    read_word(1, 0, 800, "t6.plane1_first");

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bus.ifm_enable_write_previous  = ($urandom_range(0, 99) < 60);
      bus.ifm_address_write_previous = AW'($urandom_range(0, PW - 1));
      bus.data_in_from_previous      = DW'($urandom);
      bus.start_from_previous        = ($urandom_range(0, 99) < 3);
      bus.ifm_enable_read_next       = ($urandom_range(0, 99) < 50);
      bus.ifm_plane_read_next        = PB'($urandom_range(0, NP - 1));
      bus.ifm_address_read_next      = AW'($urandom_range(0, PW - 1));
      bus.end_from_next              = ($urandom_range(0, 99) < 4);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
